stop_watch_ctrl: RTL and testbench

Button-driven controller that sequences the 4-digit BCD stop-watch counter. It debounces two raw push-buttons and runs a start/pause/lap/clear state machine. It drives the counter's go and clr inputs and selects whether the display shows the live count or a latched lap value. It sits between the board buttons and the stop-watch datapath. Its display outputs feed the seven-segment mux.

---
 rtl/stop_watch_ctrl.sv | 133 +++++++++++++
 tb/tb_stop_watch_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// Stop-watch button controller: sync + debounce + start/pause/lap/clear FSM; raw edge to go = DB_CYCLES+4 cycles.
// No backpressure (buttons are level inputs); AUTO_STOP_EN makes the count stop at 9999 instead of wrapping.
module stop_watch_ctrl #(
    parameter int DB_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] cnt3,
    input  logic [3:0] cnt2,
    input  logic [3:0] cnt1,
    input  logic [3:0] cnt0,
    output logic       go,
    output logic       clr,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       running,
    output logic       lap_active
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    // Bit 0 is start/stop, bit 1 is lap/reset.
    logic [1:0]    sync1_q, sync2_q, db_q, db_dly_q, press_q;
    logic [CW-1:0] db_cnt_q [2];

    state_t      state_q, state_d;
    logic        go_q, go_d, clr_q, clr_d, rst_q;
    logic [15:0] lap_q, lap_d;
    logic [15:0] cnt_all;
    logic        ss_p, lr_p, at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q  <= {btn_lr, btn_ss};
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign ss_p    = press_q[0];
    assign lr_p    = press_q[1];
    assign cnt_all = {cnt3, cnt2, cnt1, cnt0};

`ifdef AUTO_STOP_EN
    assign at_max = (cnt_all == 16'h9999);
`else
    assign at_max = 1'b0;
`endif

    // rst_q keeps clr asserted for one extra cycle after reset drops.
    always_comb begin
        state_d = state_q;
        clr_d   = rst_q;
        lap_d   = lap_q;
        case (state_q)
            IDLE: begin
                if (ss_p)      state_d = RUN;
                else if (lr_p) clr_d   = 1'b1;
            end
            RUN: begin
                if (at_max || ss_p) begin
                    state_d = PAUSE;
                end else if (lr_p) begin
                    state_d = LAP;
                    lap_d   = cnt_all;
                end
            end
            LAP: begin
                if (at_max || ss_p) state_d = PAUSE;
                else if (lr_p)      state_d = RUN;
            end
            PAUSE: begin
                if (ss_p && !at_max) begin
                    state_d = RUN;
                end else if (lr_p) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        go_d = (state_d == RUN) || (state_d == LAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            clr_q   <= 1'b1;
            rst_q   <= 1'b1;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            clr_q   <= clr_d;
            rst_q   <= 1'b0;
            lap_q   <= lap_d;
        end
    end

    assign go         = go_q;
    assign clr        = clr_q;
    assign running    = (state_q == RUN) || (state_q == LAP);
    assign lap_active = (state_q == LAP);

    always_comb begin
        if (state_q == LAP) {disp3, disp2, disp1, disp0} = lap_q;
        else                {disp3, disp2, disp1, disp0} = cnt_all;
    end
endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with DB_CYCLES=4 (raw edge to go = 8 edges).
module tb_stop_watch_ctrl;
    logic       clk = 1'b0;
    logic       reset, btn_ss, btn_lr;
    logic [15:0] cnt_v;
    logic       go, clr, running, lap_active;
    logic [3:0] disp3, disp2, disp1, disp0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stop_watch_ctrl #(.DB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .cnt3(cnt_v[15:12]), .cnt2(cnt_v[11:8]), .cnt1(cnt_v[7:4]), .cnt0(cnt_v[3:0]),
        .go(go), .clr(clr),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
        .running(running), .lap_active(lap_active)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
    endtask

    task automatic release_btns();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        step(8);
    endtask

    initial begin
        reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; cnt_v = 16'h1234;
        // Reset and clr stretch
        step(3);
        chk("rst_go", {15'd0, go}, 16'd0);
        chk("rst_clr", {15'd0, clr}, 16'd1);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_lap", {15'd0, lap_active}, 16'd0);
        chk("rst_disp", {disp3, disp2, disp1, disp0}, 16'h1234);
        reset = 1'b0;
        step(1);
        chk("clr_after_rst", {15'd0, clr}, 16'd1);
        step(1);
        chk("clr_drop", {15'd0, clr}, 16'd0);

        // Start press latency and single pulse on hold
        cnt_v = 16'h0000;
        press(1'b1, 1'b0);
        step(7);
        chk("go_edge7", {15'd0, go}, 16'd0);
        step(1);
        chk("go_edge8", {15'd0, go}, 16'd1);
        chk("run_running", {15'd0, running}, 16'd1);
        step(2);
        release_btns();
        chk("hold_one_pulse", {15'd0, go}, 16'd1);
        // 3-cycle glitch must not register
        btn_ss = 1'b1;
        step(3);
        btn_ss = 1'b0;
        step(10);
        chk("glitch_ignored", {15'd0, go}, 16'd1);

        // Lap latch and return
        cnt_v = 16'h0123;
        press(1'b0, 1'b1);
        step(8);
        chk("lap_active", {15'd0, lap_active}, 16'd1);
        chk("lap_go", {15'd0, go}, 16'd1);
        cnt_v = 16'h0127;
        #1;
        chk("lap_disp_frozen", {disp3, disp2, disp1, disp0}, 16'h0123);
        release_btns();
        chk("lap_disp_hold", {disp3, disp2, disp1, disp0}, 16'h0123);
        press(1'b0, 1'b1);
        step(8);
        chk("lap_exit", {15'd0, lap_active}, 16'd0);
        chk("lap_exit_run", {15'd0, running}, 16'd1);
        chk("live_disp", {disp3, disp2, disp1, disp0}, 16'h0127);
        release_btns();

        // Pause then clear
        press(1'b1, 1'b0);
        step(8);
        chk("pause_go", {15'd0, go}, 16'd0);
        chk("pause_running", {15'd0, running}, 16'd0);
        release_btns();
        press(1'b0, 1'b1);
        step(7);
        chk("clr_before", {15'd0, clr}, 16'd0);
        step(1);
        chk("clr_pulse", {15'd0, clr}, 16'd1);
        chk("idle_lap", {15'd0, lap_active}, 16'd0);
        step(1);
        chk("clr_one_cycle", {15'd0, clr}, 16'd0);
        release_btns();

        // Simultaneous presses in RUN: start/stop wins
        press(1'b1, 1'b0);
        step(8);
        chk("run_again", {15'd0, go}, 16'd1);
        release_btns();
        cnt_v = 16'h0456;
        press(1'b1, 1'b1);
        step(8);
        chk("both_go", {15'd0, go}, 16'd0);
        chk("both_nolap", {15'd0, lap_active}, 16'd0);
        chk("both_noclr", {15'd0, clr}, 16'd0);
        chk("both_disp", {disp3, disp2, disp1, disp0}, 16'h0456);
        step(1);
        chk("both_noclr2", {15'd0, clr}, 16'd0);
        release_btns();

        // Terminal count behaviour
        press(1'b1, 1'b0);
        step(8);
        chk("resume", {15'd0, go}, 16'd1);
        release_btns();
        cnt_v = 16'h9999;
        step(1);
`ifdef AUTO_STOP_EN
        chk("auto_stop_go", {15'd0, go}, 16'd0);
        chk("auto_stop_run", {15'd0, running}, 16'd0);
        press(1'b1, 1'b0);
        step(8);
        chk("auto_ss_ignored", {15'd0, go}, 16'd0);
        release_btns();
        press(1'b0, 1'b1);
        step(8);
        chk("auto_clr", {15'd0, clr}, 16'd1);
        release_btns();
`else
        chk("wrap_go", {15'd0, go}, 16'd1);
        step(5);
        chk("wrap_go_hold", {15'd0, go}, 16'd1);
`endif
        cnt_v = 16'h0000;

        // Button held through a mid-run reset
        press(1'b1, 1'b0);
        step(3);
        reset = 1'b1;
        step(2);
        chk("mid_rst_go", {15'd0, go}, 16'd0);
        chk("mid_rst_clr", {15'd0, clr}, 16'd1);
        reset = 1'b0;
        step(7);
        chk("held_edge7", {15'd0, go}, 16'd0);
        step(1);
        chk("held_edge8", {15'd0, go}, 16'd1);
        release_btns();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
